alu_operand_stage: RTL

ID/EX pipeline stage that sits directly upstream of the ALU: it registers the decoded operands, ALU opcode and destination info, and feeds the ALU's A/B/Op inputs for one instruction per cycle. It resolves operand bypassing from the MEM and WB stages and detects load-use hazards. It implements a valid/ready handshake with decode and EX, plus flush and a saturating stall counter.

---
 rtl/alu_operand_stage_pkg.sv | 32 +++
 rtl/alu_operand_stage_if.sv | 41 ++++
 rtl/alu_operand_stage_operand_bypass.sv | 28 ++
 rtl/alu_operand_stage.sv | 105 ++++++++++
 4 files changed

// File: rtl/alu_operand_stage_pkg.sv
// Shared encodings for the ID/EX operand stage: ALU opcodes, operand selects, datapath widths.
package alu_operand_stage_pkg;

    localparam int ALUOP_WIDTH = 5;
    localparam int REG_W       = 5;
    localparam int DATA_W      = 32;

    typedef enum logic [ALUOP_WIDTH-1:0] {
        ALU_NOP = 5'd0,
        ALU_ADD = 5'd1,
        ALU_SUB = 5'd2,
        ALU_AND = 5'd3,
        ALU_OR  = 5'd4,
        ALU_XOR = 5'd5,
        ALU_NOR = 5'd6,
        ALU_SLT = 5'd7,
        ALU_SLL = 5'd8,
        ALU_SRL = 5'd9,
        ALU_SRA = 5'd10,
        ALU_LUI = 5'd11
    } alu_op_e;

    localparam logic A_SEL_RS    = 1'b0;
    localparam logic A_SEL_SHAMT = 1'b1;
    localparam logic B_SEL_RT    = 1'b0;
    localparam logic B_SEL_IMM   = 1'b1;

    function automatic logic [DATA_W-1:0] shamt_ext(input logic [REG_W-1:0] shamt);
        return {{(DATA_W-REG_W){1'b0}}, shamt};
    endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// Decode-side and EX-side handshake bundle of the ID/EX operand stage.
interface alu_operand_stage_if #(parameter int ALUOP_W = alu_operand_stage_pkg::ALUOP_WIDTH);
    import alu_operand_stage_pkg::*;

    logic                id_valid;
    logic                id_ready;
    logic [REG_W-1:0]    id_rs_addr;
    logic [REG_W-1:0]    id_rt_addr;
    logic [REG_W-1:0]    id_rd_addr;
    logic                id_reg_we;
    logic [DATA_W-1:0]   id_rs_data;
    logic [DATA_W-1:0]   id_rt_data;
    logic [DATA_W-1:0]   id_imm;
    logic [REG_W-1:0]    id_shamt;
    logic                id_a_sel;
    logic                id_b_sel;
    logic [ALUOP_W-1:0]  id_alu_op;

    logic                ex_valid;
    logic                ex_ready;
    logic [DATA_W-1:0]   ex_a;
    logic [DATA_W-1:0]   ex_b;
    logic [ALUOP_W-1:0]  ex_op;
    logic [REG_W-1:0]    ex_rd;
    logic                ex_we;

    modport master (
        output id_valid, id_rs_addr, id_rt_addr, id_rd_addr, id_reg_we,
               id_rs_data, id_rt_data, id_imm, id_shamt, id_a_sel, id_b_sel,
               id_alu_op, ex_ready,
        input  id_ready, ex_valid, ex_a, ex_b, ex_op, ex_rd, ex_we
    );

    modport slave (
        input  id_valid, id_rs_addr, id_rt_addr, id_rd_addr, id_reg_we,
               id_rs_data, id_rt_data, id_imm, id_shamt, id_a_sel, id_b_sel,
               id_alu_op, ex_ready,
        output id_ready, ex_valid, ex_a, ex_b, ex_op, ex_rd, ex_we
    );

endinterface

// File: rtl/alu_operand_stage_operand_bypass.sv
// Forwarding mux for one register-sourced operand: MEM (non-load) beats WB beats register file.
module operand_bypass
    import alu_operand_stage_pkg::*;
(
    input  logic [REG_W-1:0]  addr,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              mem_we,
    input  logic              mem_is_load,
    input  logic [REG_W-1:0]  mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wb_we,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        data = rf_data;
        if (addr != '0) begin
            if (mem_we && !mem_is_load && (mem_rd == addr)) begin
                data = mem_data;
            end else if (wb_we && (wb_rd == addr)) begin
                data = wb_data;
            end
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX register feeding the ALU: operand bypass, load-use interlock, valid/ready handshake,
// flush and a saturating stall counter.
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int ALUOP_W = ALUOP_WIDTH,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    alu_operand_stage_if.slave  bus,
    input  logic                mem_we,
    input  logic                mem_is_load,
    input  logic [REG_W-1:0]    mem_rd,
    input  logic [DATA_W-1:0]   mem_data,
    input  logic                wb_we,
    input  logic [REG_W-1:0]    wb_rd,
    input  logic [DATA_W-1:0]   wb_data,
    output logic [CNT_W-1:0]    stall_cnt
);

    logic                valid_q, we_q, a_sel_q, b_sel_q;
    logic [DATA_W-1:0]   a_q, b_q;
    logic [ALUOP_W-1:0]  op_q;
    logic [REG_W-1:0]    rd_q, rs_q, rt_q;
    logic [DATA_W-1:0]   rs_fwd, rt_fwd;
    logic                load_use, id_ready, capture, a_snoop, b_snoop;

    operand_bypass u_byp_a (
        .addr(bus.id_rs_addr), .rf_data(bus.id_rs_data),
        .mem_we, .mem_is_load, .mem_rd, .mem_data,
        .wb_we, .wb_rd, .wb_data, .data(rs_fwd)
    );

    operand_bypass u_byp_b (
        .addr(bus.id_rt_addr), .rf_data(bus.id_rt_data),
        .mem_we, .mem_is_load, .mem_rd, .mem_data,
        .wb_we, .wb_rd, .wb_data, .data(rt_fwd)
    );

    // A load in MEM cannot forward yet; only sources the instruction actually reads interlock.
    assign load_use = mem_we && mem_is_load && (mem_rd != '0) &&
                      (((bus.id_a_sel == A_SEL_RS) && (bus.id_rs_addr == mem_rd)) ||
                       ((bus.id_b_sel == B_SEL_RT) && (bus.id_rt_addr == mem_rd)));

    assign id_ready = (!valid_q || bus.ex_ready) && !load_use && !flush;
    assign capture  = bus.id_valid && id_ready;

    assign a_snoop = wb_we && (wb_rd != '0) && (a_sel_q == A_SEL_RS) && (wb_rd == rs_q);
    assign b_snoop = wb_we && (wb_rd != '0) && (b_sel_q == B_SEL_RT) && (wb_rd == rt_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            a_sel_q <= A_SEL_RS;
            b_sel_q <= B_SEL_RT;
        end else if (flush) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
        end else if (capture) begin
            valid_q <= 1'b1;
            we_q    <= bus.id_reg_we;
            a_q     <= (bus.id_a_sel == A_SEL_SHAMT) ? shamt_ext(bus.id_shamt) : rs_fwd;
            b_q     <= (bus.id_b_sel == B_SEL_IMM) ? bus.id_imm : rt_fwd;
            op_q    <= bus.id_alu_op;
            rd_q    <= bus.id_rd_addr;
            rs_q    <= bus.id_rs_addr;
            rt_q    <= bus.id_rt_addr;
            a_sel_q <= bus.id_a_sel;
            b_sel_q <= bus.id_b_sel;
        end else if (valid_q && bus.ex_ready) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
        end else if (valid_q) begin
            // Held instruction keeps tracking WB so it never leaves with stale data.
            if (a_snoop) a_q <= wb_data;
            if (b_snoop) b_q <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (bus.id_valid && !id_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign bus.id_ready = id_ready;
    assign bus.ex_valid = valid_q;
    assign bus.ex_a     = a_q;
    assign bus.ex_b     = b_q;
    assign bus.ex_op    = op_q;
    assign bus.ex_rd    = rd_q;
    assign bus.ex_we    = we_q && valid_q;

endmodule
